// File: rtl/aidc_lite_comp_sel.sv
// ---------------------------------------------------------------------------
// aidc_lite_comp_sel
//
// Result buffer and selector for the AIDC-Lite compression datapath.
// Every compressor channel writes its encoded block into a private buffer in
// parallel. When done_i arrives, the shortest non-failed result is chosen and
// streamed out on a valid/ready read port. If no usable result exists, a raw
// fallback is signalled instead.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wren_i          per-channel buffer write enable
//   waddr_i         per-channel write address, channel c at [c*ADDR_W +: ADDR_W]
//   wdata_i         per-channel write data, channel c at [c*DATA_W +: DATA_W]
//   fail_i          per-channel fail indication (sticky until block end)
//   done_i          one-cycle pulse: all channels finished the block
//   sel_valid_o     one-cycle pulse: selection result valid
//   sel_raw_o       no usable channel, raw fallback
//   sel_ch_o        winning channel (0 when raw)
//   sel_len_o       winning length in beats (0 when raw)
//   rd_valid_o      output beat valid
//   rd_ready_i      output beat accept
//   rd_data_o       output beat data
//   rd_last_o       final beat of the selected stream
//   busy_o          selecting or draining
//   err_o           sticky protocol error (write/done outside COLLECT)
// ---------------------------------------------------------------------------
module aidc_lite_comp_sel #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          wren_i,
    input  logic [NUM_CH*ADDR_W-1:0]   waddr_i,
    input  logic [NUM_CH*DATA_W-1:0]   wdata_i,
    input  logic [NUM_CH-1:0]          fail_i,
    input  logic                       done_i,
    output logic                       sel_valid_o,
    output logic                       sel_raw_o,
    output logic [CH_W-1:0]            sel_ch_o,
    output logic [ADDR_W:0]            sel_len_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_last_o,
    output logic                       busy_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SELECT  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);

    state_t              state;
    logic [DATA_W-1:0]   mem [NUM_CH][DEPTH];
    logic [ADDR_W:0]     len_q [NUM_CH];
    logic [NUM_CH-1:0]   fail_q;
    logic [ADDR_W:0]     rd_idx;

    logic [ADDR_W:0]     wr_len [NUM_CH];
    logic                win_found;
    logic [CH_W-1:0]     win_ch;
    logic [ADDR_W:0]     win_len;
    logic                handshake;

    // Length a write would imply for each channel (address + 1).
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_len[c] = {1'b0, waddr_i[c*ADDR_W +: ADDR_W]} + ONE_LEN;
        end
    end

    // Pick the shortest non-failed, non-empty channel. The strict '<' keeps
    // the lowest index on ties because channels are scanned upwards.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        win_len   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!fail_q[c] && (len_q[c] != '0) && (!win_found || (len_q[c] < win_len))) begin
                win_found = 1'b1;
                win_ch    = CH_W'(c);
                win_len   = len_q[c];
            end
        end
    end

    assign handshake = rd_valid_o && rd_ready_i;
    assign busy_o    = (state != COLLECT);

    // Buffer RAM: written only while collecting, never reset.
    always_ff @(posedge clk) begin
        if (state == COLLECT) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wren_i[c]) begin
                    mem[c][waddr_i[c*ADDR_W +: ADDR_W]] <= wdata_i[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Main FSM with registered outputs. Lengths and fail flags are tracked
    // during COLLECT and cleared whenever the block is finished (raw result
    // or last beat handshaken). The first beat is fetched in SELECT so that
    // it is presented together with sel_valid_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            fail_q      <= '0;
            rd_idx      <= '0;
            sel_valid_o <= 1'b0;
            sel_raw_o   <= 1'b0;
            sel_ch_o    <= '0;
            sel_len_o   <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_last_o   <= 1'b0;
            err_o       <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                len_q[c] <= '0;
            end
        end else begin
            sel_valid_o <= 1'b0;

            if ((state != COLLECT) && ((|wren_i) || done_i)) begin
                err_o <= 1'b1;
            end

            case (state)
                COLLECT: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (wren_i[c] && (wr_len[c] > len_q[c])) begin
                            len_q[c] <= wr_len[c];
                        end
                    end
                    fail_q <= fail_q | fail_i;
                    if (done_i) begin
                        state <= SELECT;
                    end
                end

                SELECT: begin
                    sel_valid_o <= 1'b1;
                    if (win_found) begin
                        sel_raw_o  <= 1'b0;
                        sel_ch_o   <= win_ch;
                        sel_len_o  <= win_len;
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= mem[win_ch][{ADDR_W{1'b0}}];
                        rd_last_o  <= (win_len == ONE_LEN);
                        rd_idx     <= ONE_LEN;
                        state      <= DRAIN;
                    end else begin
                        sel_raw_o <= 1'b1;
                        sel_ch_o  <= '0;
                        sel_len_o <= '0;
                        fail_q    <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            len_q[c] <= '0;
                        end
                        state <= COLLECT;
                    end
                end

                DRAIN: begin
                    if (handshake) begin
                        if (rd_last_o) begin
                            rd_valid_o <= 1'b0;
                            rd_last_o  <= 1'b0;
                            fail_q     <= '0;
                            for (int c = 0; c < NUM_CH; c++) begin
                                len_q[c] <= '0;
                            end
                            state <= COLLECT;
                        end else begin
                            rd_data_o <= mem[sel_ch_o][rd_idx[ADDR_W-1:0]];
                            rd_last_o <= ((rd_idx + ONE_LEN) == sel_len_o);
                            rd_idx    <= rd_idx + ONE_LEN;
                        end
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_sel.sv
// ---------------------------------------------------------------------------
// tb_aidc_lite_comp_sel
//
// Self-checking bench for aidc_lite_comp_sel (NUM_CH=2, DATA_W=64, DEPTH=16).
// A table of block descriptions (per-channel lengths, fail pulses and the
// hand-computed winner) is replayed, followed by hand-written sequences for
// backpressure, protocol errors and reset in the middle of a stream.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_aidc_lite_comp_sel;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CH_W   = 1;

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         wren_i;
    logic [NUM_CH*ADDR_W-1:0]  waddr_i;
    logic [NUM_CH*DATA_W-1:0]  wdata_i;
    logic [NUM_CH-1:0]         fail_i;
    logic                      done_i;
    logic                      sel_valid_o;
    logic                      sel_raw_o;
    logic [CH_W-1:0]           sel_ch_o;
    logic [ADDR_W:0]           sel_len_o;
    logic                      rd_valid_o;
    logic                      rd_ready_i;
    logic [DATA_W-1:0]         rd_data_o;
    logic                      rd_last_o;
    logic                      busy_o;
    logic                      err_o;

    int total_cnt;
    int pass_cnt;

    aidc_lite_comp_sel #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wren_i      (wren_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .fail_i      (fail_i),
        .done_i      (done_i),
        .sel_valid_o (sel_valid_o),
        .sel_raw_o   (sel_raw_o),
        .sel_ch_o    (sel_ch_o),
        .sel_len_o   (sel_len_o),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .rd_last_o   (rd_last_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         blk;
        int         len0;
        int         len1;
        logic [1:0] fdone;
        logic       exp_raw;
        int         exp_ch;
        int         exp_len;
    } vec_t;

    vec_t vecs [9];

    // Data written by channel c at beat i of block blk; unique per block so
    // stale RAM content from an earlier block cannot be mistaken for it.
    function automatic logic [63:0] pat(input int blk, input int c, input int i);
        return {16'hA5A5, 8'(blk), 8'(c), 32'(i * 3 + 7)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Writes one block (channels write addr 0..len-1 in parallel), asserting
    // done_i together with the final write and fail_i per fdone in that same
    // cycle. Returns at the falling edge after done_i was sampled.
    task automatic applyStimulus(input int blk, input int l0, input int l1, input logic [1:0] fdone);
        int n;
        n = (l0 > l1) ? l0 : l1;
        if (n == 0) n = 1;
        for (int cyc = 0; cyc < n; cyc++) begin
            wren_i  = '0;
            waddr_i = '0;
            wdata_i = '0;
            if (cyc < l0) begin
                wren_i[0]        = 1'b1;
                waddr_i[3:0]     = 4'(cyc);
                wdata_i[63:0]    = pat(blk, 0, cyc);
            end
            if (cyc < l1) begin
                wren_i[1]        = 1'b1;
                waddr_i[7:4]     = 4'(cyc);
                wdata_i[127:64]  = pat(blk, 1, cyc);
            end
            done_i = (cyc == n - 1);
            fail_i = (cyc == n - 1) ? fdone : 2'b00;
            @(negedge clk);
        end
        wren_i = '0;
        waddr_i = '0;
        wdata_i = '0;
        done_i = 1'b0;
        fail_i = '0;
    endtask

    // Checks the SELECT cycle and the selection result two cycles after done_i.
    task automatic check_sel(input logic exp_raw, input int exp_ch, input int exp_len);
        checkOutput("busy_in_select", 64'(busy_o), 64'd1);
        checkOutput("sel_valid_early", 64'(sel_valid_o), 64'd0);
        @(negedge clk);
        checkOutput("sel_valid", 64'(sel_valid_o), 64'd1);
        checkOutput("sel_raw", 64'(sel_raw_o), 64'(exp_raw));
        checkOutput("sel_ch", 64'(sel_ch_o), 64'(exp_ch));
        checkOutput("sel_len", 64'(sel_len_o), 64'(exp_len));
        checkOutput("rd_valid_at_sel", 64'(rd_valid_o), exp_raw ? 64'd0 : 64'd1);
        if (exp_raw) begin
            checkOutput("busy_after_raw", 64'(busy_o), 64'd0);
            @(negedge clk);
            checkOutput("sel_valid_pulse", 64'(sel_valid_o), 64'd0);
            checkOutput("rd_valid_raw", 64'(rd_valid_o), 64'd0);
        end
    endtask

    // Drains len beats with rd_ready_i high. poke_k pulses a wren during that
    // beat (protocol error); abort_k asserts rst mid-beat. -1 disables either.
    task automatic drain_full(input int blk, input int ch, input int len,
                              input int poke_k, input int abort_k);
        rd_ready_i = 1'b1;
        for (int k = 0; k < len; k++) begin
            checkOutput($sformatf("rd_valid_b%0d", k), 64'(rd_valid_o), 64'd1);
            checkOutput($sformatf("rd_data_b%0d", k), rd_data_o, pat(blk, ch, k));
            checkOutput($sformatf("rd_last_b%0d", k), 64'(rd_last_o), (k == len - 1) ? 64'd1 : 64'd0);
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("abort_rd_valid", 64'(rd_valid_o), 64'd0);
                checkOutput("abort_rd_data", rd_data_o, 64'd0);
                checkOutput("abort_busy", 64'(busy_o), 64'd0);
                checkOutput("abort_sel_len", 64'(sel_len_o), 64'd0);
                checkOutput("abort_err", 64'(err_o), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            if (k == poke_k) begin
                wren_i       = 2'b01;
                waddr_i      = '0;
                wdata_i      = {NUM_CH*DATA_W{1'b1}};
            end
            @(negedge clk);
            wren_i  = '0;
            wdata_i = '0;
        end
        checkOutput("rd_valid_after", 64'(rd_valid_o), 64'd0);
        checkOutput("busy_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int k;
        total_cnt  = 0;
        pass_cnt   = 0;
        rst        = 1'b1;
        wren_i     = '0;
        waddr_i    = '0;
        wdata_i    = '0;
        fail_i     = '0;
        done_i     = 1'b0;
        rd_ready_i = 1'b0;

        //          blk len0 len1 fdone  raw  ch len
        vecs[0] = '{1,  6,   4,   2'b00, 1'b0, 1, 4};
        vecs[1] = '{2,  3,   3,   2'b00, 1'b0, 0, 3};
        vecs[2] = '{3,  7,   2,   2'b10, 1'b0, 0, 7};
        vecs[3] = '{4,  2,   2,   2'b11, 1'b1, 0, 0};
        vecs[4] = '{5,  1,   0,   2'b00, 1'b0, 0, 1};
        vecs[5] = '{6,  0,   5,   2'b00, 1'b0, 1, 5};
        vecs[6] = '{7,  0,   0,   2'b00, 1'b1, 0, 0};
        vecs[7] = '{8,  16,  16,  2'b00, 1'b0, 0, 16};
        vecs[8] = '{9,  16,  15,  2'b01, 1'b0, 1, 15};

        repeat (3) @(negedge clk);
        checkOutput("reset_sel_valid", 64'(sel_valid_o), 64'd0);
        checkOutput("reset_rd_valid", 64'(rd_valid_o), 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_err", 64'(err_o), 64'd0);
        checkOutput("reset_rd_data", rd_data_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            rd_ready_i = 1'b1;
            applyStimulus(vecs[v].blk, vecs[v].len0, vecs[v].len1, vecs[v].fdone);
            check_sel(vecs[v].exp_raw, vecs[v].exp_ch, vecs[v].exp_len);
            if (!vecs[v].exp_raw) begin
                drain_full(vecs[v].blk, vecs[v].exp_ch, vecs[v].exp_len, -1, -1);
            end
            @(negedge clk);
        end
        checkOutput("err_clean", 64'(err_o), 64'd0);

        // Backpressure: rd_ready toggles 1,0,1,0,... over a 5-beat stream.
        rd_ready_i = 1'b0;
        applyStimulus(20, 5, 0, 2'b00);
        check_sel(1'b0, 0, 5);
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
            checkOutput($sformatf("bp_valid_c%0d", cyc), 64'(rd_valid_o), 64'd1);
            checkOutput($sformatf("bp_data_c%0d", cyc), rd_data_o, pat(20, 0, k));
            checkOutput($sformatf("bp_last_c%0d", cyc), 64'(rd_last_o), (k == 4) ? 64'd1 : 64'd0);
            rd_ready_i = ((cyc % 2) == 0);
            if (rd_ready_i) k++;
            @(negedge clk);
        end
        rd_ready_i = 1'b0;
        checkOutput("bp_beats", 64'(k), 64'd5);
        checkOutput("bp_valid_end", 64'(rd_valid_o), 64'd0);
        @(negedge clk);

        // Write during DRAIN: flagged as error, drained data unaffected.
        applyStimulus(30, 4, 6, 2'b00);
        check_sel(1'b0, 0, 4);
        drain_full(30, 0, 4, 1, -1);
        checkOutput("err_set", 64'(err_o), 64'd1);
        @(negedge clk);

        // Reset in the middle of a stream aborts it and clears err_o.
        applyStimulus(31, 6, 4, 2'b00);
        check_sel(1'b0, 1, 4);
        drain_full(31, 1, 4, -1, 2);

        // Next block after the abort behaves normally.
        applyStimulus(32, 6, 4, 2'b00);
        check_sel(1'b0, 1, 4);
        drain_full(32, 1, 4, -1, -1);
        checkOutput("err_final", 64'(err_o), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
